uart_rx_v2: RTL and testbench

UART_RX_V2 -- requirements
Module: uart_rx_v2

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_tick_gen.sv | 29 ++
 rtl/uart_rx_v2.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_v2.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity-mode codes and a
// parameter-legality check used at elaboration time.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic bit rx_params_legal(input int data_bits, input int ovs,
                                         input int clks_per_tick, input int stop_bits);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (ovs >= 8) && (ovs <= 32) && ((ovs % 2) == 0) &&
           (clks_per_tick >= 1) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_TICK enabled cycles,
// held at zero while clear is high. Shared by receiver and future transmitter.
module uart_rx_tick_gen #(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_v2.sv
// Oversampling UART receiver with ready/valid output and overrun detection.
// Optional parity support is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_v2
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int OVS           = 16,
  parameter int CLKS_PER_TICK = 54,
  parameter int STOP_BITS     = 1
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_rx_en,
  input  logic                 I_rs232_rxd,
  input  logic [1:0]           I_parity_mode,
  output logic [DATA_BITS-1:0] O_data,
  output logic                 O_valid,
  input  logic                 I_ready,
  output logic                 O_frame_err,
  output logic                 O_parity_err,
  output logic                 O_overrun,
  output logic                 O_busy
);

  if (!rx_params_legal(DATA_BITS, OVS, CLKS_PER_TICK, STOP_BITS)) begin : g_bad_params
    $error("uart_rx_v2: illegal parameter combination");
  end

  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [OW-1:0] MID_START = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] LAST_TICK = OW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_e state, state_next;

  logic                 rxd_meta, rxd, rxd_prev;
  logic                 tick;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 stop_last;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 start_pt, bit_pt;
  logic                 parity_on;
  logic                 done;

  // Line idles high, so the synchroniser and edge-detect history reset to 1.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rxd_meta <= 1'b1;
      rxd      <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= I_rs232_rxd;
      rxd      <= rxd_meta;
      rxd_prev <= rxd;
    end
  end

  uart_rx_tick_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_tick_gen (
    .clk   (I_clk),
    .rst   (I_rst),
    .clear (state == ST_IDLE),
    .enable(I_rx_en),
    .tick  (tick)
  );

  // Start bit is re-checked at its middle; later samples are one bit apart from there.
  assign start_pt  = tick && (os_cnt == MID_START);
  assign bit_pt    = tick && (os_cnt == LAST_TICK);
  assign stop_last = (STOP_BITS == 2) ? stop_cnt : 1'b1;
  assign done      = I_rx_en && (state == ST_STOP) && bit_pt && stop_last;

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_mode;
  logic       perr_acc;
  assign parity_on = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^I_parity_mode;
  assign parity_on = 1'b0;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    if (!I_rx_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (rxd_prev && !rxd) state_next = ST_START;
        ST_START:     if (start_pt) state_next = rxd ? ST_IDLE : ST_DATA;
        ST_DATA:      if (bit_pt && (bit_cnt == LAST_BIT))
                        state_next = parity_on ? ST_PARITY : ST_STOP;
        ST_PARITY:    if (bit_pt) state_next = ST_STOP;
        ST_STOP:      if (bit_pt && stop_last) state_next = rxd ? ST_IDLE : ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (rxd) state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mode <= PAR_NONE;
      perr_acc <= 1'b0;
`endif
    end else if (state == ST_IDLE) begin
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mode <= I_parity_mode;  // frozen for the whole frame once IDLE is left
      perr_acc <= 1'b0;
`endif
    end else if (tick) begin
      os_cnt <= ((state == ST_START) ? start_pt : bit_pt) ? '0 : os_cnt + 1'b1;
      if ((state == ST_DATA) && bit_pt) begin
        shreg   <= {rxd, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if ((state == ST_PARITY) && bit_pt)
        perr_acc <= (^shreg) ^ rxd ^ (par_mode == PAR_ODD);
`endif
      if ((state == ST_STOP) && bit_pt) begin
        stop_cnt <= 1'b1;
        if (!rxd) ferr_acc <= 1'b1;
      end
    end
  end

  // A completed frame is dropped while an unaccepted word is still held.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_data      <= '0;
      O_valid     <= 1'b0;
      O_frame_err <= 1'b0;
      O_overrun   <= 1'b0;
    end else begin
      O_overrun <= 1'b0;
      if (done) begin
        if (O_valid && !I_ready) begin
          O_overrun <= 1'b1;
        end else begin
          O_data      <= shreg;
          O_frame_err <= ferr_acc | ~rxd;
          O_valid     <= 1'b1;
        end
      end else if (O_valid && I_ready) begin
        O_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge I_clk) begin
    if (I_rst)                          perr_q <= 1'b0;
    else if (done && !(O_valid && !I_ready)) perr_q <= perr_acc;
  end
  assign O_parity_err = perr_q;
`else
  assign O_parity_err = 1'b0;
`endif

  assign O_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed + randomized bench for uart_rx_v2 (8N1, 16x oversample, 4 clk/tick).
// Expected words come from a frame-level model; parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_v2;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       rxd = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } word_t;
  word_t got[$];

  always #5 clk = ~clk;

  uart_rx_v2 #(
    .DATA_BITS(8), .OVS(16), .CLKS_PER_TICK(4), .STOP_BITS(1)
  ) dut (
    .I_clk        (clk),
    .I_rst        (rst),
    .I_rx_en      (rx_en),
    .I_rs232_rxd  (rxd),
    .I_parity_mode(parity_mode),
    .O_data       (data),
    .O_valid      (valid),
    .I_ready      (ready),
    .O_frame_err  (frame_err),
    .O_parity_err (parity_err),
    .O_overrun    (overrun),
    .O_busy       (busy)
  );

  // Every accepted word (valid && ready) and every overrun pulse, seen mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid && ready) got.push_back('{data, frame_err, parity_err});
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit has_parity(input logic [1:0] mode);
    return PAR_BUILD && (mode == 2'b01 || mode == 2'b10);
  endfunction

  // Model: even mode flags an odd number of ones over data+parity, odd mode an even number.
  function automatic logic model_perr(input logic [7:0] d, input logic [1:0] mode, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (!has_parity(mode)) return 1'b0;
    return (mode == 2'b01) ? (ones % 2 != 0) : (ones % 2 == 0);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic pbit, input logic stop_bit);
    parity_mode = mode;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    if (has_parity(mode)) drive_bit(pbit, BIT_CLKS);
    drive_bit(stop_bit, BIT_CLKS);
    drive_bit(1'b1, 40);
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    word_t w;
    check({tag, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      w = got.pop_front();
      check({tag, "_data"}, w.data, d);
      check({tag, "_ferr"}, w.ferr, fe);
      check({tag, "_perr"}, w.perr, pe);
    end
    got.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] mode;
    logic       pbit, sbit;
    int         ovr_base;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
    expect_word("a5", 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    check("a5_valid_low", valid, 0);
    check("a5_idle", busy, 0);

    // Random frames, occasional bad stop bit, random parity mode when built in
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom);
      mode = PAR_BUILD ? 2'($urandom_range(0, 3)) : 2'b00;
      pbit = 1'($urandom);
      sbit = ($urandom_range(0, 3) != 0);
      send_frame(d, mode, pbit, sbit);
      expect_word($sformatf("rnd%0d", n), d, !sbit, model_perr(d, mode, pbit));
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 2'b01, 1'b1, 1'b1);
    expect_word("par_even_bad", 8'h03, 1'b0, 1'b1);
    send_frame(8'h03, 2'b01, 1'b0, 1'b1);
    expect_word("par_even_ok", 8'h03, 1'b0, 1'b0);
    parity_mode = 2'b00;
`endif

    // Short glitch is a false start
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 100);
    check("glitch_none", got.size(), 0);
    check("glitch_idle", busy, 0);

    // Break: frame of zeros with frame error, then waits for the line to rise
    drive_bit(1'b0, 630);
    @(negedge clk);
    check("break_wait_busy", busy, 1);
    expect_word("break", 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_bit(1'b0, 9);
    drive_bit(1'b1, 20);
    check("break_released", busy, 0);
    check("break_no_extra", got.size(), 0);

    // Overrun: second frame dropped while the first is unaccepted
    ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check("ovr_held_valid", valid, 1);
    check("ovr_held_data", data, 8'h11);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    @(posedge clk); #1;
    ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    expect_word("ovr_drain", 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_valid_fell", valid, 0);

    // Abort mid-DATA, reception blocked while disabled, then a clean frame
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, 30);
    rx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_idle", busy, 0);
    @(posedge clk); #1;
    drive_bit(1'b1, 100);
    drive_bit(1'b0, 200);
    drive_bit(1'b1, 100);
    check("disabled_idle", busy, 0);
    check("abort_none", got.size(), 0);
    rx_en = 1'b1;
    drive_bit(1'b1, 10);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    expect_word("after_abort", 8'h5A, 1'b0, 1'b0);

    // Reset mid-frame while a word is held
    ready = 1'b0;
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1);
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, 20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    send_frame(8'h96, 2'b00, 1'b0, 1'b1);
    expect_word("post_rst", 8'h96, 1'b0, 1'b0);
    check("total_overruns", ovr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
